// File: rtl/shape_test_sequencer_pkg.sv
// Shared types and widths for the shape detector regression sequencer.
// Build option: SHAPE_SEQ_TIMEOUT_EN enables the result-wait timeout.
package shape_pkg;

    localparam int SHAPE_W    = 2;
    localparam int IDX_W      = 2;
    localparam int MAX_IMAGES = 4;

    typedef enum logic [SHAPE_W-1:0] {
        SHAPE_UNKNOWN  = 2'b00,
        SHAPE_CIRCLE   = 2'b01,
        SHAPE_SQUARE   = 2'b10,
        SHAPE_TRIANGLE = 2'b11
    } shape_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_RES,
        S_RELEASE,
        S_FINISH
    } seq_state_t;

    // Counter width able to hold (max_val - 1).
    function automatic int tmr_width(input int max_val);
        return (max_val < 3) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/shape_test_sequencer_if.sv
// Start/result handshake between the sequencer and the detector system.
// Build option: SHAPE_SEQ_TIMEOUT_EN (no effect on this interface).
interface shape_test_sequencer_if;
    import shape_pkg::*;

    logic               start_test;
    logic [IDX_W-1:0]   image_select;
    logic [SHAPE_W-1:0] det_shape_type;
    logic               det_result_valid;

    modport master (
        output start_test,
        output image_select,
        input  det_shape_type,
        input  det_result_valid
    );

    modport slave (
        input  start_test,
        input  image_select,
        output det_shape_type,
        output det_result_valid
    );

endinterface

// File: rtl/shape_test_sequencer_timer.sv
// Loadable down-counter with zero flag; holds at zero.
// Build option: SHAPE_SEQ_TIMEOUT_EN widens it via the top-level width.
module shape_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shape_test_sequencer.sv
// Regression sweep controller for shape_detector_system.
// Build option: SHAPE_SEQ_TIMEOUT_EN adds the WAIT_RES timeout.
module shape_test_sequencer
    import shape_pkg::*;
#(
    parameter int NUM_IMAGES     = 4,
    parameter int RELEASE_CYCLES = 4
`ifdef SHAPE_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   abort,
    input  logic [7:0]             expected_map,
    shape_test_sequencer_if.master det,
    output logic                   busy,
    output logic                   done,
    output logic [MAX_IMAGES-1:0]  pass_mask,
    output logic [2:0]             fail_count,
    output logic [SHAPE_W-1:0]     last_shape,
    output logic                   timeout_flag
);

`ifdef SHAPE_SEQ_TIMEOUT_EN
    localparam int TMR_MAX = (TIMEOUT_CYCLES > RELEASE_CYCLES)
                           ? TIMEOUT_CYCLES : RELEASE_CYCLES;
`else
    localparam int TMR_MAX = RELEASE_CYCLES;
`endif
    localparam int TW = tmr_width(TMR_MAX);
    localparam logic [TW-1:0] REL_LOAD = TW'(RELEASE_CYCLES - 1);
`ifdef SHAPE_SEQ_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMAGES - 1);

    seq_state_t            state_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  start_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  abort_q;
    logic [MAX_IMAGES-1:0] pass_q;
    logic [2:0]            fail_q;
    logic [SHAPE_W-1:0]    last_q;

    logic                  tmr_load;
    logic [TW-1:0]         tmr_val;
    logic                  tmr_dec;
    logic                  tmr_zero;
    logic                  match;
    logic                  to_hit;

    assign match = (det.det_shape_type
                    == expected_map[{idx_q, 1'b0} +: 2]);

`ifdef SHAPE_SEQ_TIMEOUT_EN
    logic to_q;
    // A result arriving in the expiry cycle takes precedence.
    assign to_hit = tmr_zero & ~det.det_result_valid;
    assign timeout_flag = to_q;
`else
    assign to_hit = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = REL_LOAD;
        tmr_dec  = 1'b0;
        unique case (state_q)
            S_LAUNCH: begin
                tmr_load = 1'b1;
`ifdef SHAPE_SEQ_TIMEOUT_EN
                if (!abort) tmr_val = TO_LOAD;
`endif
            end
            S_WAIT_RES: begin
                tmr_load = abort | det.det_result_valid | to_hit;
                tmr_dec  = ~tmr_load;
            end
            S_RELEASE: tmr_dec = 1'b1;
            S_FINISH:  tmr_load = abort;
            default: ;
        endcase
    end

    shape_seq_timer #(
        .W (TW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            last_q  <= '0;
`ifdef SHAPE_SEQ_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (run && !abort) begin
                        pass_q  <= '0;
                        fail_q  <= '0;
                        idx_q   <= '0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_LAUNCH;
`ifdef SHAPE_SEQ_TIMEOUT_EN
                        to_q    <= 1'b0;
`endif
                    end
                end
                S_LAUNCH: begin
                    if (abort) begin
                        start_q <= 1'b0;
                        abort_q <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        state_q <= S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    if (abort) begin
                        start_q <= 1'b0;
                        abort_q <= 1'b1;
                        state_q <= S_RELEASE;
                    end else if (det.det_result_valid) begin
                        last_q        <= det.det_shape_type;
                        pass_q[idx_q] <= match;
                        if (!match) fail_q <= fail_q + 3'd1;
                        start_q <= 1'b0;
                        state_q <= S_RELEASE;
`ifdef SHAPE_SEQ_TIMEOUT_EN
                    end else if (to_hit) begin
                        pass_q[idx_q] <= 1'b0;
                        fail_q  <= fail_q + 3'd1;
                        to_q    <= 1'b1;
                        start_q <= 1'b0;
                        state_q <= S_RELEASE;
`endif
                    end
                end
                S_RELEASE: begin
                    if (abort) abort_q <= 1'b1;
                    if (tmr_zero) begin
                        if (abort_q || abort) begin
                            abort_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            start_q <= 1'b1;
                            state_q <= S_LAUNCH;
                        end
                    end
                end
                S_FINISH: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    start_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign det.start_test   = start_q;
    assign det.image_select = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_mask  = pass_q;
    assign fail_count = fail_q;
    assign last_shape = last_q;

endmodule

// File: tb/tb_shape_test_sequencer.sv
// Directed vector bench for shape_test_sequencer with a detector model.
// Build option: SHAPE_SEQ_TIMEOUT_EN adds the timeout scenario.
module tb_shape_test_sequencer;
    import shape_pkg::*;

    localparam int REL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] exp_map = 8'h00;
    logic       busy;
    logic       done;
    logic [3:0] pass_mask;
    logic [2:0] fail_count;
    logic [1:0] last_shape;
    logic       timeout_flag;

    shape_test_sequencer_if dif ();

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    bit         model_en = 1'b0;
    int         model_delay = 0;
    int         hang_img = -1;
    logic [7:0] cur_rsp = 8'h00;
    int         wcnt = 0;

    always #5 clk = ~clk;

    shape_test_sequencer #(
        .NUM_IMAGES     (4),
        .RELEASE_CYCLES (REL)
`ifdef SHAPE_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (64)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .abort        (abort),
        .expected_map (exp_map),
        .det          (dif),
        .busy         (busy),
        .done         (done),
        .pass_mask    (pass_mask),
        .fail_count   (fail_count),
        .last_shape   (last_shape),
        .timeout_flag (timeout_flag)
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Detector model: result after model_delay cycles, held until start drops.
    initial begin
        dif.det_result_valid = 1'b0;
        dif.det_shape_type   = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (model_en) begin
                if (!dif.start_test) begin
                    wcnt = 0;
                    dif.det_result_valid = 1'b0;
                end else if (!dif.det_result_valid) begin
                    if (wcnt >= model_delay
                        && int'(dif.image_select) != hang_img) begin
                        dif.det_shape_type =
                            cur_rsp[{dif.image_select, 1'b0} +: 2];
                        dif.det_result_valid = 1'b1;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " start_test"}, 32'(dif.start_test), 0);
        chk({tag, " image_select"}, 32'(dif.image_select), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " pass_mask"}, 32'(pass_mask), 0);
        chk({tag, " fail_count"}, 32'(fail_count), 0);
        chk({tag, " last_shape"}, 32'(last_shape), 0);
        chk({tag, " timeout_flag"}, 32'(timeout_flag), 0);
    endtask

    // Pulse run, optionally pulse run again mid-sweep, wait for done.
    task automatic sweep(input string tag, input bit rerun);
        bit seen;
        int d0;
        seen = 1'b0;
        d0 = done_cnt;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (rerun && i == 3) run = 1'b1;
            if (rerun && i == 4) run = 1'b0;
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        run = 1'b0;
        chk({tag, " done seen"}, 32'(seen), 1);
        tick();
        chk({tag, " done width"}, 32'(done), 0);
        chk({tag, " busy after"}, 32'(busy), 0);
        chk({tag, " done count"}, 32'(done_cnt - d0), 1);
    endtask

    typedef struct {
        logic [7:0] map;
        logic [7:0] rsp;
        int         dly;
        logic [3:0] pm;
        logic [2:0] fc;
        logic [1:0] ls;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hE4, 8'hE4, 0, 4'hF, 3'd0, 2'd3};
        vecs[1] = '{8'hE4, 8'hD4, 2, 4'hB, 3'd1, 2'd3};
        vecs[2] = '{8'h00, 8'h79, 1, 4'h0, 3'd4, 2'd1};
        vecs[3] = '{8'hFF, 8'hCF, 5, 4'hB, 3'd1, 2'd3};
        vecs[4] = '{8'h1B, 8'h13, 3, 4'hD, 3'd1, 2'd0};

        #2 rst_n = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        model_en = 1'b1;
        foreach (vecs[k]) begin
            exp_map     = vecs[k].map;
            cur_rsp     = vecs[k].rsp;
            model_delay = vecs[k].dly;
            sweep($sformatf("vec%0d", k), k[0]);
            chk($sformatf("vec%0d pass_mask", k),
                32'(pass_mask), 32'(vecs[k].pm));
            chk($sformatf("vec%0d fail_count", k),
                32'(fail_count), 32'(vecs[k].fc));
            chk($sformatf("vec%0d last_shape", k),
                32'(last_shape), 32'(vecs[k].ls));
            chk($sformatf("vec%0d timeout_flag", k),
                32'(timeout_flag), 0);
        end

        // Hand-driven handshake timing, then abort in image 1.
        model_en = 1'b0;
        tick();
        dif.det_result_valid = 1'b0;
        dif.det_shape_type   = 2'b00;
        exp_map = 8'hE4;
        begin
            int d0;
            d0 = done_cnt;
            run = 1'b1;
            tick();
            run = 1'b0;
            chk("launch start", 32'(dif.start_test), 1);
            chk("launch sel", 32'(dif.image_select), 0);
            chk("launch busy", 32'(busy), 1);
            tick();
            tick();
            chk("wait start held", 32'(dif.start_test), 1);
            dif.det_result_valid = 1'b1;
            tick();
            dif.det_result_valid = 1'b0;
            chk("img0 pass", 32'(pass_mask), 1);
            for (int i = 0; i < REL; i++) begin
                chk($sformatf("release low %0d", i),
                    32'(dif.start_test), 0);
                tick();
            end
            chk("relaunch start", 32'(dif.start_test), 1);
            chk("relaunch sel", 32'(dif.image_select), 1);
            tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort start low", 32'(dif.start_test), 0);
            for (int i = 0; i < REL - 1; i++) tick();
            chk("abort busy in release", 32'(busy), 1);
            tick();
            chk("abort busy idle", 32'(busy), 0);
            chk("abort no done", 32'(done_cnt - d0), 0);
            chk("abort partial pass", 32'(pass_mask), 1);
            chk("abort partial fail", 32'(fail_count), 0);
            chk("abort sel held", 32'(dif.image_select), 1);
        end

        run = 1'b1;
        abort = 1'b1;
        tick();
        run = 1'b0;
        abort = 1'b0;
        tick();
        chk("run+abort idle busy", 32'(busy), 0);
        chk("run+abort start", 32'(dif.start_test), 0);

        // Run while busy is ignored, then async reset mid-WAIT_RES.
        model_en    = 1'b1;
        exp_map     = 8'hE4;
        cur_rsp     = 8'hE4;
        model_delay = 20;
        begin
            bit found;
            int d0;
            found = 1'b0;
            d0 = done_cnt;
            run = 1'b1;
            tick();
            run = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (dif.image_select == 2'd1 && dif.start_test) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            chk("reach image1", 32'(found), 1);
            run = 1'b1;
            tick();
            run = 1'b0;
            tick();
            chk("busy run ignored sel", 32'(dif.image_select), 1);
            chk("busy run ignored pass", 32'(pass_mask), 1);
            tick();
            rst_n = 1'b0;
            #1;
            chk_reset_vals("midreset");
            tick();
            chk("midreset no done", 32'(done_cnt - d0), 0);
            #2 rst_n = 1'b1;
            tick();
        end
        model_delay = 0;
        sweep("postreset", 1'b0);
        chk("postreset pass_mask", 32'(pass_mask), 32'hF);

`ifdef SHAPE_SEQ_TIMEOUT_EN
        hang_img = 3;
        sweep("timeout", 1'b0);
        chk("timeout pass_mask", 32'(pass_mask), 32'h7);
        chk("timeout fail_count", 32'(fail_count), 1);
        chk("timeout last_shape", 32'(last_shape), 2);
        chk("timeout flag", 32'(timeout_flag), 1);
        hang_img = -1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
